// File: rtl/timer_pkg.sv
// Shared encodings for the tick timer controller: channel time units and the
// decade wrap value used by the ms and s prescaler stages.
package timer_pkg;
   localparam logic [1:0] UNIT_US    = 2'd0;
   localparam logic [1:0] UNIT_MS    = 2'd1;
   localparam logic [1:0] UNIT_S     = 2'd2;
   localparam logic [9:0] DECADE_MAX = 10'd999;
endpackage

// File: rtl/tick_prescaler.sv
// Derives 1 us, 1 ms and 1 s single-cycle enable strobes from clk; every
// strobe is a registered output in the clk domain, so no derived clocks exist.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int CLK_MHZ = 50
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_us,
   output logic tick_ms,
   output logic tick_s
);

   logic [5:0] us_cnt;
   logic [9:0] ms_cnt;
   logic [9:0] s_cnt;
   logic       us_wrap;
   logic       ms_wrap;
   logic       s_wrap;

   // Wraps cascade on the same edge, so tick_ms/tick_s coincide with tick_us.
   assign us_wrap = (us_cnt == 6'(CLK_MHZ - 1));
   assign ms_wrap = us_wrap && (ms_cnt == DECADE_MAX);
   assign s_wrap  = ms_wrap && (s_cnt == DECADE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt  <= '0;
         ms_cnt  <= '0;
         s_cnt   <= '0;
         tick_us <= 1'b0;
         tick_ms <= 1'b0;
         tick_s  <= 1'b0;
      end else begin
         tick_us <= us_wrap;
         tick_ms <= ms_wrap;
         tick_s  <= s_wrap;
         us_cnt  <= us_wrap ? '0 : us_cnt + 6'd1;
         if (us_wrap) ms_cnt <= (ms_cnt == DECADE_MAX) ? '0 : ms_cnt + 10'd1;
         if (ms_wrap) s_cnt  <= (s_cnt == DECADE_MAX) ? '0 : s_cnt + 10'd1;
      end
   end

endmodule

// File: rtl/tick_timer_ctrl.sv
// Multi-channel countdown timer: NUM_CH channels count us/ms/s strobes from the
// shared prescaler and emit a one-cycle expire pulse when their count runs out.
module tick_timer_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_MHZ = 50,
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [1:0]        cfg_unit,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              cfg_periodic,
   output logic              tick_us,
   output logic              tick_ms,
   output logic              tick_s,
   output logic [NUM_CH-1:0] active,
   output logic [NUM_CH-1:0] expire
);

   // Channel index bits above clog2(NUM_CH) are masked off, not range-checked.
   localparam logic [2:0] CH_MASK = 3'((1 << $clog2(NUM_CH)) - 1);

   logic       cfg_fire;
   logic [2:0] wr_ch;

   assign cfg_fire = cfg_valid && cfg_ready;
   assign wr_ch    = cfg_ch & CH_MASK;

   tick_prescaler #(
      .CLK_MHZ (CLK_MHZ)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_us (tick_us),
      .tick_ms (tick_ms),
      .tick_s  (tick_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_ready <= 1'b0;
      else        cfg_ready <= 1'b1;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] remaining;
      logic [CNT_W-1:0] reload;
      logic [1:0]       ch_unit;
      logic             periodic;
      logic             act;
      logic             exp_pulse;
      logic             sel;
      logic             wr;

      assign wr        = cfg_fire && (wr_ch == 3'(i));
      assign active[i] = act;
      assign expire[i] = exp_pulse;

      // The reserved unit encoding falls through to seconds.
      always_comb begin
         case (ch_unit)
            UNIT_US: sel = tick_us;
            UNIT_MS: sel = tick_ms;
            default: sel = tick_s;
         endcase
      end

      // A write takes priority over a strobe, which also suppresses expiry.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            remaining <= '0;
            reload    <= '0;
            ch_unit   <= UNIT_US;
            periodic  <= 1'b0;
            act       <= 1'b0;
            exp_pulse <= 1'b0;
         end else begin
            exp_pulse <= 1'b0;
            if (wr) begin
               remaining <= cfg_count;
               reload    <= cfg_count;
               ch_unit   <= cfg_unit;
               periodic  <= cfg_periodic;
               act       <= (cfg_count != '0);
            end else if (act && sel) begin
               if (remaining > CNT_W'(1)) begin
                  remaining <= remaining - CNT_W'(1);
               end else begin
                  exp_pulse <= 1'b1;
                  if (periodic) begin
                     remaining <= reload;
                  end else begin
                     act       <= 1'b0;
                     remaining <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Randomised self-checking bench for tick_timer_ctrl; the reference model
// predicts strobe and expiry edges arithmetically from edges since reset release.
module tb_tick_timer_ctrl;
   localparam int     CLK_MHZ = 50;
   localparam int     NUM_CH  = 4;
   localparam int     CNT_W   = 16;
   localparam longint P_US    = CLK_MHZ;
   localparam longint P_MS    = longint'(CLK_MHZ) * 1000;
   localparam longint P_S     = longint'(CLK_MHZ) * 1000000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [2:0]        cfg_ch = '0;
   logic [1:0]        cfg_unit = '0;
   logic [CNT_W-1:0]  cfg_count = '0;
   logic              cfg_periodic = 1'b0;
   logic              tick_us, tick_ms, tick_s;
   logic [NUM_CH-1:0] active, expire;

   int total = 0;
   int bad   = 0;

   // Model state: edges since release, per-channel next expiry edge and period.
   longint            n_edge = 0;
   logic [NUM_CH-1:0] m_act = '0;
   logic [NUM_CH-1:0] m_exp = '0;
   longint            m_next [NUM_CH];
   longint            m_step [NUM_CH];
   logic              m_per  [NUM_CH];

   tick_timer_ctrl #(
      .CLK_MHZ (CLK_MHZ),
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_unit     (cfg_unit),
      .cfg_count    (cfg_count),
      .cfg_periodic (cfg_periodic),
      .tick_us      (tick_us),
      .tick_ms      (tick_ms),
      .tick_s       (tick_s),
      .active       (active),
      .expire       (expire)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic longint unit_period(input logic [1:0] u);
      case (u)
         2'd0:    return P_US;
         2'd1:    return P_MS;
         default: return P_S;
      endcase
   endfunction

   task automatic model_reset();
      n_edge = 0;
      m_act  = '0;
      m_exp  = '0;
   endtask

   // One clock: drive cfg, advance the model across the edge, return at negedge.
   task automatic cycle(input logic v, input logic [2:0] ch, input logic [1:0] u,
                        input logic [CNT_W-1:0] n, input logic per);
      logic   rdy_m;
      longint p, s1;
      int     wc;
      cfg_valid    = v;
      cfg_ch       = ch;
      cfg_unit     = u;
      cfg_count    = n;
      cfg_periodic = per;
      rdy_m = (n_edge >= 1);
      @(posedge clk);
      n_edge++;
      m_exp = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_act[c] && m_next[c] == n_edge) begin
            m_exp[c] = 1'b1;
            if (m_per[c]) m_next[c] += m_step[c];
            else          m_act[c] = 1'b0;
         end
      end
      if (v && rdy_m) begin
         wc = int'(ch) & (NUM_CH - 1);
         m_exp[wc] = 1'b0;
         if (n == '0) begin
            m_act[wc] = 1'b0;
         end else begin
            p  = unit_period(u);
            s1 = ((n_edge - 1) / p + 1) * p + 1;
            m_act[wc]  = 1'b1;
            m_next[wc] = s1 + (longint'(n) - 1) * p;
            m_step[wc] = longint'(n) * p;
            m_per[wc]  = per;
         end
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic idle();
      cycle(1'b0, 3'd0, 2'd0, '0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({cfg_ready, tick_us, tick_ms, tick_s} !== 4'b0 || active !== '0 || expire !== '0) begin
         bad++;
         $display("FAIL reset_state: ready=%b ticks=%b%b%b active=%b expire=%b want all 0",
                  cfg_ready, tick_us, tick_ms, tick_s, active, expire);
      end
      rst_n = 1'b1;
      model_reset();
      idle();
      total++;
      if (cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_release: got %b want 1", cfg_ready);
      end
   endtask

   task automatic test_prescaler();
      int  errs = 0;
      int  us_seen = 0;
      bit  ms_seen = 0;
      logic e_us, e_ms;
      while (n_edge < P_MS + P_US + 2) begin
         idle();
         e_us = (n_edge % P_US == 0);
         e_ms = (n_edge % P_MS == 0);
         if (errs < 8) begin
            total++;
            if (tick_us !== e_us || tick_ms !== e_ms || tick_s !== 1'b0 || expire !== '0) begin
               bad++; errs++;
               $display("FAIL prescaler edge %0d: us/ms/s=%b%b%b want %b%b0 expire=%b",
                        n_edge, tick_us, tick_ms, tick_s, e_us, e_ms, expire);
            end
         end
         if (tick_us === 1'b1) us_seen++;
         if (tick_ms === 1'b1 && !ms_seen) begin
            ms_seen = 1;
            total++;
            if (us_seen != 1000 || tick_us !== 1'b1) begin
               bad++;
               $display("FAIL first_tick_ms: us count %0d tick_us=%b want 1000 and 1", us_seen, tick_us);
            end
         end
      end
      total++;
      if (!ms_seen) begin
         bad++;
         $display("FAIL tick_ms_present: got none want one");
      end
   endtask

   task automatic test_oneshot();
      longint w, e = -1;
      int     pulses = 0;
      int     errs = 0;
      cycle(1'b1, 3'd0, 2'd0, 16'd3, 1'b0);
      w = n_edge;
      repeat (int'(25 * P_US)) begin
         idle();
         if (errs < 8) begin
            total++;
            if (expire !== m_exp || active !== m_act) begin
               bad++; errs++;
               $display("FAIL oneshot edge %0d: expire=%b active=%b want %b %b",
                        n_edge, expire, active, m_exp, m_act);
            end
         end
         if (expire[0] === 1'b1) begin
            pulses++;
            e = n_edge;
            total++;
            if (active[0] !== 1'b0) begin
               bad++;
               $display("FAIL oneshot_active_fall: active0=%b want 0", active[0]);
            end
         end
      end
      total++;
      if (pulses != 1 || e - w < 2 * P_US || e - w > 3 * P_US) begin
         bad++;
         $display("FAIL oneshot_timing: pulses=%0d delay=%0d want 1 pulse delay %0d..%0d",
                  pulses, e - w, 2 * P_US, 3 * P_US);
      end
   endtask

   task automatic test_periodic();
      longint last = -1;
      int     pulses = 0;
      int     errs = 0;
      cycle(1'b1, 3'd1, 2'd0, 16'd2, 1'b1);
      for (int k = 0; k < 12 * 100 && pulses < 10; k++) begin
         idle();
         if (errs < 8) begin
            total++;
            if (expire !== m_exp || active[1] !== 1'b1) begin
               bad++; errs++;
               $display("FAIL periodic edge %0d: expire=%b active=%b want %b active1=1",
                        n_edge, expire, active, m_exp);
            end
         end
         if (expire[1] === 1'b1) begin
            if (last >= 0) begin
               total++;
               if (n_edge - last != 2 * P_US) begin
                  bad++;
                  $display("FAIL periodic_interval: got %0d want %0d", n_edge - last, 2 * P_US);
               end
            end
            last = n_edge;
            pulses++;
         end
      end
      total++;
      if (pulses != 10) begin
         bad++;
         $display("FAIL periodic_count: got %0d want 10", pulses);
      end
      cycle(1'b1, 3'd1, 2'd0, 16'd0, 1'b0);
      total++;
      if (active[1] !== 1'b0 || expire[1] !== 1'b0) begin
         bad++;
         $display("FAIL periodic_stop: active1=%b expire1=%b want 0 0", active[1], expire[1]);
      end
      errs = 0;
      repeat (300) begin
         idle();
         if (errs < 4) begin
            total++;
            if (expire !== '0 || active !== m_act) begin
               bad++; errs++;
               $display("FAIL after_stop: expire=%b active=%b want 0 %b", expire, active, m_act);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      longint e0 = -1, e2 = -2;
      for (int k = 0; k < 2 * P_US && n_edge % P_US != 4; k++) idle();
      cycle(1'b1, 3'd0, 2'd0, 16'd1, 1'b0);
      cycle(1'b1, 3'd2, 2'd0, 16'd1, 1'b0);
      repeat (int'(3 * P_US)) begin
         idle();
         total++;
         if (expire !== m_exp) begin
            bad++;
            $display("FAIL b2b edge %0d: expire=%b want %b", n_edge, expire, m_exp);
         end
         if (expire[0] === 1'b1) e0 = n_edge;
         if (expire[2] === 1'b1) e2 = n_edge;
      end
      total++;
      if (e0 != e2) begin
         bad++;
         $display("FAIL b2b_same_cycle: expire0 edge %0d expire2 edge %0d want equal", e0, e2);
      end
   endtask

   task automatic test_write_at_expiry();
      bit hit = 0;
      int errs = 0;
      cycle(1'b1, 3'd0, 2'd0, 16'd4, 1'b0);
      for (int k = 0; k < 1000 && !hit; k++) begin
         if (m_act[0] && m_next[0] == n_edge + 1) hit = 1;
         else idle();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL collide_setup: expiry edge not reached within budget");
      end else begin
         cycle(1'b1, 3'd4, 2'd0, 16'd2, 1'b0);
         total++;
         if (expire[0] !== 1'b0 || active[0] !== 1'b1) begin
            bad++;
            $display("FAIL collide_write_wins: expire0=%b active0=%b want 0 1", expire[0], active[0]);
         end
      end
      repeat (int'(4 * P_US)) begin
         idle();
         if (errs < 8) begin
            total++;
            if (expire !== m_exp || active !== m_act) begin
               bad++; errs++;
               $display("FAIL collide_reload edge %0d: expire=%b active=%b want %b %b",
                        n_edge, expire, active, m_exp, m_act);
            end
         end
      end
   endtask

   task automatic test_random();
      int errs = 0;
      int r;
      logic [1:0] u;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 7);
            u = (r < 5) ? 2'd0 : 2'(r - 4);
            cycle(1'b1, 3'($urandom_range(0, 7)), u, CNT_W'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)));
         end else begin
            idle();
         end
         if (errs < 8) begin
            total++;
            if (expire !== m_exp || active !== m_act) begin
               bad++; errs++;
               $display("FAIL random edge %0d: expire=%b active=%b want %b %b",
                        n_edge, expire, active, m_exp, m_act);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int errs = 0;
      cycle(1'b1, 3'd3, 2'd1, 16'd500, 1'b0);
      cycle(1'b1, 3'd0, 2'd0, 16'd1, 1'b1);
      repeat (200) idle();
      total++;
      if (active[3] !== 1'b1 || active[0] !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_active: active=%b want ch0 and ch3 set", active);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (active !== '0 || expire !== '0 || cfg_ready !== 1'b0 || tick_us !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: active=%b expire=%b ready=%b tick_us=%b want 0",
                  active, expire, cfg_ready, tick_us);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (500) begin
         idle();
         if (errs < 4) begin
            total++;
            if (expire !== '0 || active !== '0) begin
               bad++; errs++;
               $display("FAIL post_reset_idle: expire=%b active=%b want 0 0", expire, active);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_oneshot();
      test_periodic();
      test_back_to_back();
      test_write_at_expiry();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
